// File: rtl/div_arbiter.sv
// div_arbiter
//   Shares one iterative restoring divider between two requesters (A and B).
//   Round-robin arbitration picks one operation at a time; the divider then
//   produces one quotient bit per clock and hands the result back to the
//   granted requester through a valid/ready handshake.
//
// Parameters
//   WIDTH          operand/result width in bits (2..16)
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   in_valid_x / in_ready_x      request handshake for requester x (a or b)
//   dividend_x, divisor_x        unsigned operands of requester x
//   resp_valid_x / resp_ready_x  response handshake for requester x
//   quotient, remainder,         shared result bus, valid while the owner's
//   div_zero                     resp_valid is high
//
// Optional feature (macro DIV_ARB_STATS_EN)
//   Adds ops_a / ops_b: 16-bit wrapping counts of completed response
//   handshakes per requester, cleared by reset.
module div_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_a,
  output logic             in_ready_a,
  input  logic [WIDTH-1:0] dividend_a,
  input  logic [WIDTH-1:0] divisor_a,
  input  logic             in_valid_b,
  output logic             in_ready_b,
  input  logic [WIDTH-1:0] dividend_b,
  input  logic [WIDTH-1:0] divisor_b,
  output logic             resp_valid_a,
  input  logic             resp_ready_a,
  output logic             resp_valid_b,
  input  logic             resp_ready_b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
`ifdef DIV_ARB_STATS_EN
  ,
  output logic [15:0]      ops_a,
  output logic [15:0]      ops_b
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic             last_grant;   // 0 = A, 1 = B
  logic             owner;        // 0 = A, 1 = B
  logic [CNT_W-1:0] cnt;

  // The accumulator is WIDTH+1 bits during the trial subtraction. Its kept
  // value is always below the divisor, so the top bit is always zero and is
  // not stored.
  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] dq, dq_nx;    // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs;

  logic             accept, sel_b, last_iter, resp_hs;
  logic [WIDTH-1:0] sel_dividend, sel_divisor;

  // One restoring-division iteration: shift {acc, dividend MSB} left, try a
  // subtract, keep it and emit a 1 only when it does not go negative.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] q
  );
    logic [WIDTH:0] sh, trial;
    sh    = {a, q[WIDTH-1]};
    trial = sh - {1'b0, d};
    if (!trial[WIDTH]) return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    else               return {sh[WIDTH-1:0],    q[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    in_ready_a   = (state == IDLE) & in_valid_a & (~in_valid_b | last_grant);
    in_ready_b   = (state == IDLE) & in_valid_b & (~in_valid_a | ~last_grant);
    accept       = in_ready_a | in_ready_b;
    sel_b        = in_ready_b;
    sel_dividend = sel_b ? dividend_b : dividend_a;
    sel_divisor  = sel_b ? divisor_b  : divisor_a;
    resp_valid_a = (state == DONE) & ~owner;
    resp_valid_b = (state == DONE) &  owner;
    resp_hs      = (resp_valid_a & resp_ready_a) | (resp_valid_b & resp_ready_b);
    last_iter    = (cnt == CNT_W'(WIDTH - 1));
    {acc_nx, dq_nx} = div_step(acc, dvs, dq);

    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (sel_divisor == '0) ? DONE : RUN;
      RUN:     if (last_iter) state_nx = DONE;
      DONE:    if (resp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      quotient   <= '0;
      remainder  <= '0;
      div_zero   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (accept) begin
            owner      <= sel_b;
            last_grant <= sel_b;
            cnt        <= '0;
            // Divide-by-zero skips the iterations and answers next cycle.
            if (sel_divisor == '0) begin
              quotient  <= '1;
              remainder <= sel_dividend;
              div_zero  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_iter) begin
            cnt       <= '0;
            quotient  <= dq_nx;
            remainder <= acc_nx;
            div_zero  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Divider datapath
  always_ff @(posedge clock) begin
    if (state == IDLE && accept) begin
      acc <= '0;
      dq  <= sel_dividend;
      dvs <= sel_divisor;
    end else if (state == RUN) begin
      acc <= acc_nx;
      dq  <= dq_nx;
    end
  end

`ifdef DIV_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ops_a <= '0;
      ops_b <= '0;
    end else begin
      if (resp_valid_a & resp_ready_a) ops_a <= ops_a + 16'd1;
      if (resp_valid_b & resp_ready_b) ops_b <= ops_b + 16'd1;
    end
  end
`endif

endmodule
